// File: rtl/matmul_scratchpad.sv
// Result scratchpad behind the matmul calc stage: captures the calc result
// stream into one of SP_NTARGETS matrix slots, replays a slot as the C-bias
// operand, serves host reads and runs a per-slot clear engine.
module matmul_scratchpad #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned BUS_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned SP_NTARGETS = 4,
    localparam int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int unsigned NELEM      = MAX_DIM * MAX_DIM,
    localparam int unsigned IDXW       = 2 * $clog2(MAX_DIM),
    localparam int unsigned SELW       = $clog2(SP_NTARGETS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    // calc-stage result write stream
    input  logic [SELW-1:0]       wr_sel_i,
    input  logic                  enable_w_i,
    input  logic [ADDR_WIDTH-1:0] address_w_i,
    input  logic [BUS_WIDTH-1:0]  data_w_i,
    output logic                  wr_done_o,
    output logic                  addr_err_o,

    // C-bias stream back to the calc stage
    input  logic                  bias_en_i,
    input  logic [SELW-1:0]       bias_sel_i,
    output logic [BUS_WIDTH-1:0]  data_c_o,

    // host read port
    input  logic                  rd_en_i,
    input  logic [SELW-1:0]       rd_sel_i,
    input  logic [IDXW-1:0]       rd_idx_i,
    output logic [BUS_WIDTH-1:0]  rd_data_o,
    output logic                  rd_valid_o,

    // slot clear engine
    input  logic                  clear_i,
    input  logic [SELW-1:0]       clr_sel_i,
    output logic                  busy_o
);

    localparam int unsigned CNTW        = IDXW + 1;
    localparam logic [4:0]  RESULT_CODE = 5'b10000;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NELEM - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    // storage: SP_NTARGETS slots of NELEM result words
    logic [BUS_WIDTH-1:0] mem_q [SP_NTARGETS][NELEM];

    state_e              state_q, state_d;
    logic [IDXW-1:0]     clr_idx_q, clr_idx_d;
    logic [SELW-1:0]     clr_slot_q, clr_slot_d;
    logic                busy_q, busy_d;
    logic                clr_we_c;

    logic [CNTW-1:0]     wr_cnt_q;
    logic                wr_done_q;
    logic                addr_err_q;
    logic [IDXW-1:0]     bias_idx_q;
    logic [BUS_WIDTH-1:0] data_c_q;
    logic [BUS_WIDTH-1:0] rd_data_q;
    logic                rd_valid_q;

    logic                wr_strobe_c;
    logic                wr_accept_c;
    logic [IDXW-1:0]     wr_idx_c;
    logic                wr_last_c;
    logic                unused_addr_c;

    // decode of the calc write strobe
    assign wr_strobe_c   = enable_w_i;
    assign wr_accept_c   = enable_w_i && (address_w_i[4:0] == RESULT_CODE);
    assign wr_idx_c      = address_w_i[5 +: IDXW];
    assign wr_last_c     = (wr_cnt_q == CNTW'(NELEM - 1));
    assign unused_addr_c = ^address_w_i[ADDR_WIDTH-1:5+IDXW];

    // clear engine state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            clr_idx_q  <= '0;
            clr_slot_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            clr_slot_q <= clr_slot_d;
            busy_q     <= busy_d;
        end
    end

    // clear engine next state: walk every entry of the latched slot once
    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        clr_slot_d = clr_slot_q;
        busy_d     = 1'b0;
        clr_we_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    state_d    = ST_CLEAR;
                    clr_idx_d  = '0;
                    clr_slot_d = clr_sel_i;
                    busy_d     = 1'b1;
                end
            end
            ST_CLEAR: begin
                clr_we_c = 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                    busy_d    = 1'b0;
                end else begin
                    clr_idx_d = clr_idx_q + IDXW'(1);
                    busy_d    = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_idx_d = '0;
            end
        endcase
    end

    // storage update; the calc write is issued last so it beats a clear of the same entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SP_NTARGETS; s++) begin
                for (int e = 0; e < NELEM; e++) begin
                    mem_q[s][e] <= '0;
                end
            end
        end else begin
            if (clr_we_c) begin
                mem_q[clr_slot_q][clr_idx_q] <= '0;
            end
            if (wr_accept_c) begin
                mem_q[wr_sel_i][wr_idx_c] <= data_w_i;
            end
        end
    end

    // accepted-write counter with matrix-complete pulse, plus bad operand flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_q   <= '0;
            wr_done_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            wr_done_q  <= wr_accept_c && wr_last_c;
            addr_err_q <= wr_strobe_c && !wr_accept_c;
            if (wr_accept_c) begin
                wr_cnt_q <= wr_last_c ? '0 : wr_cnt_q + CNTW'(1);
            end
        end
    end

    // C-bias stream: one element per enabled cycle, restarting at 0 when disabled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bias_idx_q <= '0;
            data_c_q   <= '0;
        end else if (bias_en_i) begin
            data_c_q   <= mem_q[bias_sel_i][bias_idx_q];
            bias_idx_q <= (bias_idx_q == LAST_IDX) ? '0 : bias_idx_q + IDXW'(1);
        end else begin
            bias_idx_q <= '0;
            data_c_q   <= '0;
        end
    end

    // host read port; data holds when no read is requested
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= mem_q[rd_sel_i][rd_idx_i];
            end
        end
    end

    assign wr_done_o  = wr_done_q;
    assign addr_err_o = addr_err_q;
    assign data_c_o   = data_c_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_matmul_scratchpad.sv
// Self-checking bench for matmul_scratchpad: directed scenarios plus random
// traffic, all compared cycle by cycle against an array-based reference model.
module tb_matmul_scratchpad;

    localparam int unsigned DW    = 8;
    localparam int unsigned BW    = 16;
    localparam int unsigned AW    = 32;
    localparam int unsigned NT    = 4;
    localparam int unsigned NELEM = 4;
    localparam int unsigned IDXW  = 2;
    localparam int unsigned SELW  = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [SELW-1:0] wr_sel_i;
    logic            enable_w_i;
    logic [AW-1:0]   address_w_i;
    logic [BW-1:0]   data_w_i;
    logic            wr_done_o;
    logic            addr_err_o;
    logic            bias_en_i;
    logic [SELW-1:0] bias_sel_i;
    logic [BW-1:0]   data_c_o;
    logic            rd_en_i;
    logic [SELW-1:0] rd_sel_i;
    logic [IDXW-1:0] rd_idx_i;
    logic [BW-1:0]   rd_data_o;
    logic            rd_valid_o;
    logic            clear_i;
    logic [SELW-1:0] clr_sel_i;
    logic            busy_o;

    matmul_scratchpad #(
        .DATA_WIDTH (DW),
        .BUS_WIDTH  (BW),
        .ADDR_WIDTH (AW),
        .SP_NTARGETS(NT)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_sel_i   (wr_sel_i),
        .enable_w_i (enable_w_i),
        .address_w_i(address_w_i),
        .data_w_i   (data_w_i),
        .wr_done_o  (wr_done_o),
        .addr_err_o (addr_err_o),
        .bias_en_i  (bias_en_i),
        .bias_sel_i (bias_sel_i),
        .data_c_o   (data_c_o),
        .rd_en_i    (rd_en_i),
        .rd_sel_i   (rd_sel_i),
        .rd_idx_i   (rd_idx_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .clear_i    (clear_i),
        .clr_sel_i  (clr_sel_i),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_mem [NT][NELEM];
    int m_cnt, m_bidx, m_rd_hold;
    int m_clr_left, m_clr_slot, m_clr_pos;

    // observed pulse tallies for directed scenarios
    int done_seen, err_seen, busy_seen;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, want);
        end
    endtask

    task automatic idle_inputs();
        rst_i       = 1'b0;
        wr_sel_i    = '0;
        enable_w_i  = 1'b0;
        address_w_i = '0;
        data_w_i    = '0;
        bias_en_i   = 1'b0;
        bias_sel_i  = '0;
        rd_en_i     = 1'b0;
        rd_sel_i    = '0;
        rd_idx_i    = '0;
        clear_i     = 1'b0;
        clr_sel_i   = '0;
    endtask

    // advance one clock: predict with the model from current inputs, then compare
    task automatic tick();
        logic       accept;
        logic       e_done, e_err, e_valid, e_busy;
        int         e_c, e_rd, widx;
        if (rst_i) begin
            foreach (m_mem[s, e]) m_mem[s][e] = 0;
            m_cnt = 0; m_bidx = 0; m_rd_hold = 0;
            m_clr_left = 0; m_clr_pos = 0; m_clr_slot = 0;
            e_done = 0; e_err = 0; e_valid = 0; e_busy = 0; e_c = 0; e_rd = 0;
        end else begin
            accept = enable_w_i && (address_w_i[4:0] == 5'b10000);
            widx   = int'(address_w_i[6:5]);
            e_err  = enable_w_i && !accept;
            e_done = 1'b0;
            if (accept) begin
                m_cnt++;
                if (m_cnt == NELEM) begin
                    m_cnt  = 0;
                    e_done = 1'b1;
                end
            end
            e_c    = bias_en_i ? m_mem[bias_sel_i][m_bidx] : 0;
            m_bidx = bias_en_i ? (m_bidx + 1) % NELEM : 0;
            e_valid = rd_en_i;
            e_rd    = rd_en_i ? m_mem[rd_sel_i][rd_idx_i] : m_rd_hold;
            m_rd_hold = e_rd;
            if (m_clr_left > 0) begin
                m_mem[m_clr_slot][m_clr_pos] = 0;
                m_clr_pos++;
                m_clr_left--;
            end else if (clear_i) begin
                m_clr_left = NELEM;
                m_clr_slot = int'(clr_sel_i);
                m_clr_pos  = 0;
            end
            e_busy = (m_clr_left > 0);
            if (accept) m_mem[wr_sel_i][widx] = int'(data_w_i);
        end
        @(posedge clk_i);
        #1;
        check("wr_done",  32'(wr_done_o),  32'(e_done));
        check("addr_err", 32'(addr_err_o), 32'(e_err));
        check("data_c",   32'(data_c_o),   32'(e_c));
        check("rd_valid", 32'(rd_valid_o), 32'(e_valid));
        check("rd_data",  32'(rd_data_o),  32'(e_rd));
        check("busy",     32'(busy_o),     32'(e_busy));
        done_seen += int'(wr_done_o);
        err_seen  += int'(addr_err_o);
        busy_seen += int'(busy_o);
    endtask

    task automatic do_write(input int sel, input int addr, input int data);
        wr_sel_i    = SELW'(sel);
        enable_w_i  = 1'b1;
        address_w_i = AW'(addr);
        data_w_i    = BW'(data);
        tick();
        enable_w_i  = 1'b0;
    endtask

    task automatic do_read(input int sel, input int idx, input string tag, input int want);
        rd_en_i  = 1'b1;
        rd_sel_i = SELW'(sel);
        rd_idx_i = IDXW'(idx);
        tick();
        rd_en_i  = 1'b0;
        check(tag, 32'(rd_data_o), 32'(want));
        check({tag, "_valid"}, 32'(rd_valid_o), 32'd1);
    endtask

    initial begin
        int bias_want [6];
        int clr_want [NELEM];
        bias_want = '{1, 2, 3, 4, 1, 2};
        clr_want  = '{0, 0, 'h22, 0};
        done_seen = 0; err_seen = 0; busy_seen = 0;

        // reset
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_data_c", 32'(data_c_o), 32'd0);
        check("rst_busy",   32'(busy_o),   32'd0);

        // write stream into slot 1
        done_seen = 0;
        do_write(1, 'h10, 5);
        do_write(1, 'h30, -3);
        do_write(1, 'h50, 100);
        check("done_early", 32'(done_seen), 32'd0);
        do_write(1, 'h70, 'h7FFF);
        check("done_4th", 32'(wr_done_o), 32'd1);
        tick();
        check("done_once", 32'(done_seen), 32'd1);
        do_read(1, 0, "s1_i0", 5);
        do_read(1, 1, "s1_i1", 'hFFFD);
        do_read(1, 2, "s1_i2", 100);
        do_read(1, 3, "s1_i3", 'h7FFF);
        tick();
        check("rd_valid_drop", 32'(rd_valid_o), 32'd0);
        check("rd_data_hold",  32'(rd_data_o),  32'h7FFF);

        // bad operand code
        do_write(1, 'h08, 9);
        check("bad_err", 32'(addr_err_o), 32'd1);
        tick();
        check("bad_err_once", 32'(addr_err_o), 32'd0);
        do_read(1, 0, "bad_unchanged", 5);
        done_seen = 0;
        for (int i = 0; i < 4; i++) do_write(2, 'h10 + 'h20 * i, i + 1);
        tick();
        check("bad_cnt_done", 32'(done_seen), 32'd1);

        // bias stream of slot 2 = {1,2,3,4}
        bias_en_i  = 1'b1;
        bias_sel_i = 2'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bias_seq", 32'(data_c_o), 32'(bias_want[i]));
        end
        bias_en_i = 1'b0;
        tick();
        check("bias_off", 32'(data_c_o), 32'd0);
        bias_en_i = 1'b1;
        tick();
        check("bias_restart", 32'(data_c_o), 32'd1);
        bias_en_i = 1'b0;
        tick();

        // clear vs write collision on slot 0
        for (int i = 0; i < 4; i++) do_write(0, 'h10 + 'h20 * i, 'h11);
        tick();
        busy_seen = 0;
        clear_i   = 1'b1;
        clr_sel_i = 2'd0;
        tick();
        clear_i = 1'b0;
        tick();
        clear_i   = 1'b1;
        clr_sel_i = 2'd1;
        tick();
        clear_i = 1'b0;
        do_write(0, 'h50, 'h22);
        tick();
        tick();
        tick();
        check("clr_busy_cycles", 32'(busy_seen), 32'd4);
        for (int i = 0; i < NELEM; i++) do_read(0, i, "clr_final", clr_want[i]);
        do_read(1, 0, "clr_ignored", 5);

        // same-cycle read and write of one entry
        do_write(3, 'h30, 7);
        wr_sel_i    = 2'd3;
        enable_w_i  = 1'b1;
        address_w_i = 32'h30;
        data_w_i    = 16'd9;
        rd_en_i     = 1'b1;
        rd_sel_i    = 2'd3;
        rd_idx_i    = 2'd1;
        tick();
        enable_w_i = 1'b0;
        rd_en_i    = 1'b0;
        check("rw_old", 32'(rd_data_o), 32'd7);
        do_read(3, 1, "rw_new", 9);

        // reset in the second clear cycle
        clear_i   = 1'b1;
        clr_sel_i = 2'd1;
        tick();
        clear_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        done_seen = 0; err_seen = 0; busy_seen = 0;
        for (int s = 0; s < NT; s++)
            for (int e = 0; e < NELEM; e++) do_read(s, e, "mid_rst_zero", 0);
        check("mid_rst_pulses", 32'(done_seen + err_seen + busy_seen), 32'd0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            rst_i       = ($urandom_range(0, 199) == 0);
            wr_sel_i    = SELW'($urandom);
            enable_w_i  = ($urandom_range(0, 1) == 1);
            address_w_i = AW'($urandom);
            if ($urandom_range(0, 4) != 0) address_w_i[4:0] = 5'b10000;
            data_w_i    = BW'($urandom);
            if ($urandom_range(0, 7) == 0) bias_en_i = ~bias_en_i;
            bias_sel_i  = SELW'($urandom);
            rd_en_i     = ($urandom_range(0, 1) == 1);
            rd_sel_i    = SELW'($urandom);
            rd_idx_i    = IDXW'($urandom);
            clear_i     = ($urandom_range(0, 9) == 0);
            clr_sel_i   = SELW'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_scratchpad.md
Name: matmul_scratchpad

Overview:
Result scratchpad directly downstream of the matmul calculation stage. It captures the serial result-write stream (write enable, address, data) into one of SP_NTARGETS matrix slots. It streams a selected slot back as the C-bias operand in the element order the calc stage consumes. It also provides a host read port and a per-slot clear engine.

Parameters:
DATA_WIDTH, 8, operand element width in bits.
BUS_WIDTH, 16, result word width and bus width.
ADDR_WIDTH, 32, write address width.
SP_NTARGETS, 4, number of matrix slots; must be a power of 2, at least 2.
(localparams) MAX_DIM = BUS_WIDTH/DATA_WIDTH; NELEM = MAX_DIM*MAX_DIM; IDXW = 2*$clog2(MAX_DIM); SELW = $clog2(SP_NTARGETS).

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous reset, active-high.
wr_sel_i  in  SELW  slot receiving calc writes.
enable_w_i  in  1  write strobe from calc stage.
address_w_i  in  ADDR_WIDTH  write address; [4:0] operand code, [5+IDXW-1:5] element index.
data_w_i  in  BUS_WIDTH  signed result word.
wr_done_o  out  1  one-cycle pulse after NELEM accepted writes.
addr_err_o  out  1  one-cycle pulse when a strobed write has an operand code other than 5'b10000.
bias_en_i  in  1  enables the C-bias stream.
bias_sel_i  in  SELW  slot streamed as bias.
data_c_o  out  BUS_WIDTH  bias word to the calc stage.
rd_en_i  in  1  host read request.
rd_sel_i  in  SELW  host read slot.
rd_idx_i  in  IDXW  host read element index.
rd_data_o  out  BUS_WIDTH  host read data.
rd_valid_o  out  1  qualifies rd_data_o.
clear_i  in  1  clear request (single-cycle pulse).
clr_sel_i  in  SELW  slot to clear.
busy_o  out  1  high while the clear engine is active.

Behaviour:
- Reset (rst_i=1 at an edge): all NELEM*SP_NTARGETS words become 0; FSM goes to IDLE; wr_cnt, bias_idx and clr_idx become 0.
- Output reset values: wr_done_o=0, addr_err_o=0, data_c_o=0, rd_data_o=0, rd_valid_o=0, busy_o=0.
- Reset mid-clear or mid-stream aborts the operation immediately; no done pulse follows.
- Write acceptance: a write is accepted when enable_w_i=1 and address_w_i[4:0]==5'b10000.
  - On acceptance, mem[wr_sel_i][address_w_i[5+IDXW-1:5]] <= data_w_i and wr_cnt increments.
  - Other address bits are ignored.
  - A rejected strobe writes nothing, leaves wr_cnt unchanged, and pulses addr_err_o on the next cycle.
- wr_done_o: when an accepted write brings wr_cnt to NELEM, wr_cnt returns to 0 and wr_done_o is 1 for exactly the following cycle.
  - Gaps in enable_w_i do not reset wr_cnt.
- Bias stream:
  - While bias_en_i=1, on each edge data_c_o <= mem[bias_sel_i][bias_idx] and bias_idx increments, wrapping NELEM-1 -> 0.
  - The first edge with bias_en_i=1 presents element 0, so latency is 1 cycle from enable to element 0.
  - While bias_en_i=0: data_c_o <= 0 and bias_idx <= 0.
- Host read: when rd_en_i=1 at edge t, rd_data_o <= mem[rd_sel_i][rd_idx_i] and rd_valid_o=1 after t.
  - When rd_en_i=0: rd_valid_o <= 0 and rd_data_o holds its value.
- Read/write collision: reads (host and bias) sample pre-edge contents. A same-cycle write to the same entry is visible only from the next read onward.
- FSM states IDLE and CLEAR:
  - IDLE + clear_i=1 -> CLEAR. The engine latches clr_sel_i and sets clr_idx=0; busy_o=1 from the next cycle.
  - In CLEAR, each cycle mem[slot][clr_idx] <= 0 and clr_idx increments.
  - After writing clr_idx==NELEM-1 the FSM returns to IDLE and busy_o drops. CLEAR lasts exactly NELEM cycles.
  - clear_i while in CLEAR is ignored.
  - An accepted calc write to the same entry the clear engine writes in that cycle wins; the data word is kept.
  - Calc writes to other entries, and host/bias reads, proceed during CLEAR unchanged.
- Arithmetic: words are stored verbatim and signed; no saturation or bias addition happens in this block.

Test Plan:
- Reset then write stream: wr_sel_i=1, four writes with address 0x10,0x30,0x50,0x70 and data 5,-3,100,0x7FFF -> host reads of slot1 idx0..3 return 5,0xFFFD,100,0x7FFF, each with rd_valid_o one cycle after rd_en_i; wr_done_o pulses exactly once, the cycle after the 4th write.
- Bad operand: enable_w_i=1, address 0x08, data 9 -> addr_err_o pulses once, the slot stays unchanged, and wr_cnt is unaffected (the subsequent 4 good writes still give one wr_done_o).
- Bias stream: slot2 = {1,2,3,4}, bias_en_i high for 6 cycles -> data_c_o = 1,2,3,4,1,2; deassert -> data_c_o=0 and the next enable restarts at 1.
- Clear vs write collision: slot0 full of 0x11; clear_i for slot0 while writing 0x22 to idx2 in the clear's 3rd cycle -> busy_o high exactly 4 cycles; final contents {0,0,0x22,0}; clear_i pulsed during busy is ignored.
- Same-cycle read/write: slot3 idx1 = 7; write 9 and host read to the same entry in one cycle -> rd_data_o=7; next read returns 9.
- Reset mid-clear: assert rst_i in clear cycle 2 -> busy_o=0 next cycle, all memory 0, no wr_done_o/addr_err_o pulses, outputs at reset values.
